// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the analog mux scan controller.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONVERT,
        WAIT,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_dec.sv
// 2:4 decoder for the analog mux.
// The outputs are active-low: the selected channel's line is driven low.
module mux_scan_ctrl_dec
    import mux_scan_pkg::*;
(
    input  logic [CH_W-1:0]   addr,
    output logic [NUM_CH-1:0] sel
);

    // Drive every select high, then pull the addressed channel low.
    always_comb begin
        sel       = '1;
        sel[addr] = 1'b0;
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the four mux channels in order.
// For each channel it selects the channel and waits the settle time.
// It then fires one ADC conversion and captures the result.
// The result is offered downstream on a valid/ready pair.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int DATA_W        = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [CH_W-1:0]   addr,
    output logic [3:0]        sel,
    output logic              conv_start,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              frame_done
);

    // The counter is loaded with SETTLE_CYCLES-1 and counts down to 0.
    // This keeps SETTLE exactly SETTLE_CYCLES cycles long.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [CH_W-1:0]   addr_next;
    logic              capture;
    logic              accept;

    mux_scan_ctrl_dec u_dec (
        .addr (addr),
        .sel  (sel)
    );

    // conv_start is decoded from registered state.
    // CONVERT lasts one cycle, so the pulse is one clean cycle wide.
    assign conv_start = (state == CONVERT);

    // Register the state and the counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            addr  <= addr_next;
        end
    end

    // Compute the next state, counter and channel.
    // Also flag the capture and accept events for the sample register.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = addr;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                addr_next = '0;
                if (en) begin
                    cnt_next   = SETTLE_LOAD;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_next = CONVERT;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            CONVERT: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (sample_valid && sample_ready) begin
                    accept = 1'b1;
                    if (en) begin
                        addr_next  = addr + CH_W'(1);
                        cnt_next   = SETTLE_LOAD;
                        state_next = SETTLE;
                    end else begin
                        addr_next  = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Single-entry sample register.
    // It is only loaded from WAIT, so an unaccepted sample is never overwritten.
    // frame_done pulses when the channel-3 sample is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= accept && (addr == CH_W'(NUM_CH - 1));
            if (capture) begin
                sample_data  <= conv_data;
                sample_ch    <= addr;
                sample_valid <= 1'b1;
            end else if (accept) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequences the 4-channel analog mux through its 2:4 active-low decoder, one channel at a time.
- Per channel: selects the channel, waits a settle interval, starts one ADC conversion, captures the result, presents it downstream on a valid/ready handshake.
- Sits between the sensor/ADC front end and the sample-packing logic; runs continuously while enabled.

Parameters:
- SETTLE_CYCLES, 16, cycles held in SETTLE after the mux address is applied; legal range 1..65535.
- DATA_W, 12, ADC result width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  1  scan enable, level-sensitive
- addr  output  2  current mux channel
- sel  output  4  active-low channel selects, from the decoder instance driven by addr
- conv_start  output  1  one-cycle pulse requesting an ADC conversion
- conv_done  input  1  one-cycle pulse from the ADC; conv_data is valid in the same cycle
- conv_data  input  DATA_W  ADC result
- sample_data  output  DATA_W  captured result
- sample_ch  output  2  channel that sample_data belongs to
- sample_valid  output  1  sample available
- sample_ready  input  1  downstream accepts the sample
- frame_done  output  1  one-cycle pulse when the channel-3 sample is accepted

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - state IDLE, addr=0, sel=4'b1110.
  - conv_start=0, sample_valid=0, sample_data=0, sample_ch=0, frame_done=0, settle counter=0.
  - Reset wins over every other event in the same cycle, in any state, including mid-conversion. A later stray conv_done is ignored.
- States: IDLE, SETTLE, CONVERT, WAIT, HOLD.
- IDLE:
  - addr=0.
  - en=1 at an edge: load counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - addr held stable.
  - Decrement each cycle; when counter==0, go to CONVERT.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CONVERT:
  - conv_start=1 for exactly this one cycle (registered state decode, no glitch); go to WAIT.
- WAIT:
  - Wait indefinitely for conv_done (no timeout).
  - On conv_done: register conv_data into sample_data and addr into sample_ch, set sample_valid=1 from the next cycle, go to HOLD.
- HOLD:
  - sample_valid=1; sample_data and sample_ch stable until accepted.
  - On sample_valid && sample_ready: clear sample_valid next cycle. Then:
    - If addr==3, pulse frame_done for one cycle.
    - addr increments mod 4 (3 wraps to 0).
    - If en=1, load the counter and go to SETTLE. If en=0, go to IDLE with addr=0.
- Latency: en rises, sampled at edge k. conv_start is high during cycle k+SETTLE_CYCLES+1. Minimum channel period is SETTLE_CYCLES+3 cycles plus ADC conversion time, with sample_ready held high.
- en deassert mid-scan: the current channel completes through the HOLD handshake, then IDLE. There is no abort path other than reset.
- en re-assert while still in HOLD: the scan continues at the next channel; it does not restart at 0.
- conv_done in any state other than WAIT: ignored, no capture.
- sample_ready while sample_valid=0: ignored.
- Acceptance happens only in HOLD, so a result is never overwritten. No buffering beyond the single sample register.
- addr changes only on the HOLD→SETTLE/IDLE transition or reset. sel follows addr combinationally through the decoder.

Decomposition:
- Package mux_scan_pkg holds:
  - scan_state_t enum {IDLE, SETTLE, CONVERT, WAIT, HOLD};
  - localparam NUM_CH=4 and CH_W=2;
  - the settle counter width, 16 bits.
- Sub-module: instantiate the existing decoder (addr→sel) inside this block. No other sub-modules; the FSM, counter and capture registers stay in one module.

Test Plan:
- Reset then en=1, SETTLE_CYCLES=16, ADC returns 12'hABC 5 cycles after conv_start, sample_ready=1 → conv_start at cycle 17 after en sampled; sample_data=12'hABC, sample_ch=0, sample_valid high 1 cycle; addr→1, sel=4'b1101.
- Continuous scan, ADC data = 12'h100+ch → samples 100,101,102,103 on ch 0..3; frame_done pulses once on the ch-3 accept; addr wraps to 0, sel=4'b1110.
- Backpressure: sample_ready=0 for 20 cycles in HOLD, with a spurious conv_done during HOLD → sample_valid, sample_data and addr stable; no conv_start; data unchanged; advances one cycle after ready=1.
- en dropped during SETTLE of ch 2 → ch 2 completes its conversion and handshake, then IDLE with addr=0; no further conv_start.
- Synchronous reset asserted in WAIT, then a stray conv_done → all outputs return to reset values; the stray pulse is ignored; the next en restarts at ch 0.
- SETTLE_CYCLES=1 → conv_start exactly 2 cycles after en is sampled; exactly one conv_start per channel.
